// File: rtl/level_column_feeder.sv
// level_column_feeder
// Upstream stage of the block column store. After reset it prefills the
// 10-column on-screen window with level columns 0..9. During play it adds
// SCROLL_STEP pixels of scroll per frame while Mario pushes past the scroll
// line, and fetches/shifts one new column each time the scroll offset
// crosses a 40-pixel block boundary.
// Optional build macro LEVEL_WRAP_EN: the column index wraps to 0 after the
// last level column and level_end never asserts (attract/demo loop).
module level_column_feeder #(
    parameter int         LEVEL_COLS  = 200,
    parameter int         ROM_LATENCY = 1,
    parameter logic [9:0] SCROLL_X    = 10'd320,
    parameter int         SCROLL_STEP = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [9:0]  Mario_X_Pos,
    input  logic        mario_moving_right,
    output logic [7:0]  rom_addr,
    input  logic [29:0] rom_data,
    output logic [29:0] new_block_id,
    output logic        Shift,
    output logic [5:0]  scroll_offset,
    output logic        scroll_active,
    output logic        ready,
    output logic        level_end,
    output logic [7:0]  next_col
);

    typedef enum logic [2:0] {
        PF_ISSUE = 3'd0,
        PF_WAIT  = 3'd1,
        PF_SHIFT = 3'd2,
        RUN      = 3'd3,
        F_ISSUE  = 3'd4,
        F_WAIT   = 3'd5,
        F_SHIFT  = 3'd6
    } state_t;

    localparam logic [8:0] COLS_W    = 9'(LEVEL_COLS);
    localparam logic [1:0] LAT_W     = 2'(ROM_LATENCY);
    localparam logic [6:0] STEP_W    = 7'(SCROLL_STEP);
    localparam logic [6:0] BLOCK_PX  = 7'd40;
    localparam logic [3:0] LAST_FILL = 4'd9;

    state_t      state_r, state_nx_s;
    logic [7:0]  rom_addr_r, rom_addr_nx_s;
    logic [7:0]  next_col_r, next_col_nx_s;
    logic [29:0] new_block_id_r, new_block_id_nx_s;
    logic        shift_r, shift_nx_s;
    logic [5:0]  scroll_offset_r, scroll_offset_nx_s;
    logic        scroll_active_r, scroll_active_nx_s;
    logic        ready_r, ready_nx_s;
    logic        level_end_r, level_end_nx_s;
    logic [3:0]  fill_cnt_r, fill_cnt_nx_s;
    logic [1:0]  wait_cnt_r, wait_cnt_nx_s;

    logic [8:0]  col_inc_s;
    logic [7:0]  col_step_s;
    logic [6:0]  sum_s;
    logic        scroll_ok_s;

    // Helper arithmetic: column advance (with optional wrap), scroll sum, scroll qualifier
    always_comb begin
        col_inc_s   = {1'b0, next_col_r} + 9'd1;
`ifdef LEVEL_WRAP_EN
        if (col_inc_s == COLS_W) begin
            col_step_s = 8'd0;
        end else begin
            col_step_s = col_inc_s[7:0];
        end
`else
        col_step_s  = col_inc_s[7:0];
`endif
        sum_s       = {1'b0, scroll_offset_r} + STEP_W;
        scroll_ok_s = mario_moving_right && (Mario_X_Pos >= SCROLL_X) && !level_end_r;
    end

    // Next-state and next-register-value logic for the prefill/run/fetch sequencer
    always_comb begin
        state_nx_s         = state_r;
        rom_addr_nx_s      = rom_addr_r;
        next_col_nx_s      = next_col_r;
        new_block_id_nx_s  = new_block_id_r;
        shift_nx_s         = 1'b0;
        scroll_offset_nx_s = scroll_offset_r;
        scroll_active_nx_s = scroll_active_r;
        ready_nx_s         = ready_r;
        level_end_nx_s     = level_end_r;
        fill_cnt_nx_s      = fill_cnt_r;
        wait_cnt_nx_s      = wait_cnt_r;

        case (state_r)
            PF_ISSUE, F_ISSUE: begin
                rom_addr_nx_s = next_col_r;
                wait_cnt_nx_s = LAT_W;
                state_nx_s    = (state_r == PF_ISSUE) ? PF_WAIT : F_WAIT;
            end
            PF_WAIT, F_WAIT: begin
                wait_cnt_nx_s = wait_cnt_r - 2'd1;
                if (wait_cnt_r == 2'd1) begin
                    // ROM word is valid now; the strobe goes out with it next cycle
                    new_block_id_nx_s = rom_data;
                    shift_nx_s        = 1'b1;
                    state_nx_s        = (state_r == PF_WAIT) ? PF_SHIFT : F_SHIFT;
                end else begin
                    state_nx_s = state_r;
                end
            end
            PF_SHIFT: begin
                next_col_nx_s = col_step_s;
                fill_cnt_nx_s = fill_cnt_r + 4'd1;
                if (fill_cnt_r == LAST_FILL) begin
                    ready_nx_s = 1'b1;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = PF_ISSUE;
                end
            end
            F_SHIFT: begin
                next_col_nx_s = col_step_s;
                state_nx_s    = RUN;
`ifdef LEVEL_WRAP_EN
                level_end_nx_s = 1'b0;
`else
                if (col_inc_s == COLS_W) begin
                    level_end_nx_s = 1'b1;
                end else begin
                    level_end_nx_s = level_end_r;
                end
`endif
            end
            RUN: begin
                if (frame_tick) begin
                    if (scroll_ok_s) begin
                        scroll_active_nx_s = 1'b1;
                        if (sum_s >= BLOCK_PX) begin
                            // Crossed a block boundary: carry the remainder and fetch a column
                            scroll_offset_nx_s = 6'(sum_s - BLOCK_PX);
                            state_nx_s         = F_ISSUE;
                        end else begin
                            scroll_offset_nx_s = sum_s[5:0];
                        end
                    end else begin
                        scroll_active_nx_s = 1'b0;
                    end
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: begin
                state_nx_s = PF_ISSUE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= PF_ISSUE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath and output registers; Reset abandons any fetch in flight
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_r      <= 8'd0;
            next_col_r      <= 8'd0;
            new_block_id_r  <= 30'd0;
            shift_r         <= 1'b0;
            scroll_offset_r <= 6'd0;
            scroll_active_r <= 1'b0;
            ready_r         <= 1'b0;
            level_end_r     <= 1'b0;
            fill_cnt_r      <= 4'd0;
            wait_cnt_r      <= 2'd0;
        end else begin
            rom_addr_r      <= rom_addr_nx_s;
            next_col_r      <= next_col_nx_s;
            new_block_id_r  <= new_block_id_nx_s;
            shift_r         <= shift_nx_s;
            scroll_offset_r <= scroll_offset_nx_s;
            scroll_active_r <= scroll_active_nx_s;
            ready_r         <= ready_nx_s;
            level_end_r     <= level_end_nx_s;
            fill_cnt_r      <= fill_cnt_nx_s;
            wait_cnt_r      <= wait_cnt_nx_s;
        end
    end

    assign rom_addr      = rom_addr_r;
    assign next_col      = next_col_r;
    assign new_block_id  = new_block_id_r;
    assign Shift         = shift_r;
    assign scroll_offset = scroll_offset_r;
    assign scroll_active = scroll_active_r;
    assign ready         = ready_r;
    assign level_end     = level_end_r;

endmodule

// File: tb/tb_level_column_feeder.sv
// Testbench for level_column_feeder. Two instances share the clock:
// dut (LEVEL_COLS=12, ROM_LATENCY=1) and dut_b (LEVEL_COLS=200, ROM_LATENCY=3).
// Expected scroll/fetch behaviour comes from a per-tick arithmetic model.
module tb_level_column_feeder;

    localparam int LC   = 12;
    localparam int STEP = 2;
    localparam int SX   = 320;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset, frame_tick, mario_moving_right;
    logic [9:0]  Mario_X_Pos;
    logic [7:0]  rom_addr, next_col;
    logic [29:0] rom_data, new_block_id;
    logic        Shift, scroll_active, ready, level_end;
    logic [5:0]  scroll_offset;

    logic        b_Reset, b_frame_tick, b_mr;
    logic [9:0]  b_mx;
    logic [7:0]  b_rom_addr, b_next_col;
    logic [29:0] b_rom_data, b_new_block_id;
    logic        b_Shift, b_scroll_active, b_ready, b_level_end;
    logic [5:0]  b_scroll_offset;

    logic [29:0] rom_mem [0:255];
    logic [7:0]  b_p1, b_p2;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rdy_cyc = -1;
    int sh_cyc[$];
    logic [29:0] sh_word[$];
    int b_sh_cyc[$];
    logic [29:0] b_sh_word[$];

    // reference model state
    int m_off, m_next;
    bit m_active, m_end;

    level_column_feeder #(.LEVEL_COLS(LC), .ROM_LATENCY(1), .SCROLL_X(10'd320), .SCROLL_STEP(STEP)) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .Mario_X_Pos(Mario_X_Pos),
        .mario_moving_right(mario_moving_right), .rom_addr(rom_addr), .rom_data(rom_data),
        .new_block_id(new_block_id), .Shift(Shift), .scroll_offset(scroll_offset),
        .scroll_active(scroll_active), .ready(ready), .level_end(level_end), .next_col(next_col));

    level_column_feeder #(.LEVEL_COLS(200), .ROM_LATENCY(3), .SCROLL_X(10'd320), .SCROLL_STEP(STEP)) dut_b (
        .Clk(Clk), .Reset(b_Reset), .frame_tick(b_frame_tick), .Mario_X_Pos(b_mx),
        .mario_moving_right(b_mr), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
        .new_block_id(b_new_block_id), .Shift(b_Shift), .scroll_offset(b_scroll_offset),
        .scroll_active(b_scroll_active), .ready(b_ready), .level_end(b_level_end), .next_col(b_next_col));

    // ROM models: latency 1 -> word valid for the first capture edge; latency 3 -> two extra stages
    assign rom_data = rom_mem[rom_addr];
    always @(posedge Clk) begin
        b_p1 <= b_rom_addr;
        b_p2 <= b_p1;
    end
    assign b_rom_data = rom_mem[b_p2];

    always @(posedge Clk) cyc <= cyc + 1;

    // Record every Shift pulse and the first ready cycle
    always @(negedge Clk) begin
        if (Shift) begin
            sh_cyc.push_back(cyc);
            sh_word.push_back(new_block_id);
        end
        if (ready === 1'b1 && rdy_cyc < 0) rdy_cyc <= cyc;
        if (b_Shift) begin
            b_sh_cyc.push_back(cyc);
            b_sh_word.push_back(b_new_block_id);
        end
    end

    // One frame tick on dut, model update, then checks once any fetch has finished
    task automatic do_tick(input logic [9:0] x, input logic right, input bit extra, output bit fetched);
        int base, s, col;
        fetched = 1'b0;
        col = 0;
        base = sh_word.size();
        if (right && (x >= 10'(SX)) && !m_end) begin
            m_active = 1'b1;
            s = m_off + STEP;
            if (s >= 40) begin
                m_off = s - 40;
                fetched = 1'b1;
                col = m_next;
                m_next++;
                if (m_next == LC) begin
`ifdef LEVEL_WRAP_EN
                    m_next = 0;
`else
                    m_end = 1'b1;
`endif
                end
            end else begin
                m_off = s;
            end
        end else begin
            m_active = 1'b0;
        end
        Mario_X_Pos = x;
        mario_moving_right = right;
        frame_tick = 1'b1;
        @(negedge Clk);
        // optionally keep ticking through the fetch (incl. the Shift cycle): must be ignored
        for (int k = 0; k < 3; k++) begin
            frame_tick = fetched & extra;
            @(negedge Clk);
        end
        frame_tick = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if (scroll_offset !== 6'(m_off)) begin
            n_fail++; $display("FAIL tick_offset: got %0d expected %0d", scroll_offset, m_off);
        end
        n_cmp++;
        if (scroll_active !== m_active) begin
            n_fail++; $display("FAIL tick_active: got %b expected %b", scroll_active, m_active);
        end
        n_cmp++;
        if (next_col !== 8'(m_next)) begin
            n_fail++; $display("FAIL tick_next_col: got %0d expected %0d", next_col, m_next);
        end
        n_cmp++;
        if (level_end !== m_end) begin
            n_fail++; $display("FAIL tick_level_end: got %b expected %b", level_end, m_end);
        end
        n_cmp++;
        if ((sh_word.size() - base) != (fetched ? 1 : 0)) begin
            n_fail++; $display("FAIL tick_shift_count: got %0d expected %0d", sh_word.size() - base, fetched);
        end
        if (fetched && sh_word.size() > base) begin
            n_cmp++;
            if (sh_word[base] !== rom_mem[col]) begin
                n_fail++; $display("FAIL tick_word: got %h expected %h (col %0d)", sh_word[base], rom_mem[col], col);
            end
            n_cmp++;
            if (rom_addr !== 8'(col)) begin
                n_fail++; $display("FAIL tick_rom_addr: got %0d expected %0d", rom_addr, col);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; b_Reset = 1'b1;
        frame_tick = 1'b1; b_frame_tick = 1'b1;
        Mario_X_Pos = 10'd330; mario_moving_right = 1'b1;
        b_mx = 10'd330; b_mr = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({rom_addr, next_col, new_block_id, Shift, scroll_offset, scroll_active, ready, level_end} !== '0) begin
            n_fail++; $display("FAIL reset_a: got %h expected 0",
                {rom_addr, next_col, new_block_id, Shift, scroll_offset, scroll_active, ready, level_end});
        end
        n_cmp++;
        if ({b_rom_addr, b_next_col, b_new_block_id, b_Shift, b_scroll_offset, b_scroll_active, b_ready, b_level_end} !== '0) begin
            n_fail++; $display("FAIL reset_b: got %h expected 0",
                {b_rom_addr, b_next_col, b_new_block_id, b_Shift, b_scroll_offset, b_scroll_active, b_ready, b_level_end});
        end
        frame_tick = 1'b0; b_frame_tick = 1'b0;
    endtask

    task automatic test_prefill();
        int c0;
        Reset = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 100 && ready !== 1'b1; i++) begin
            frame_tick = 1'($urandom_range(0, 1));
            @(negedge Clk);
        end
        frame_tick = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (sh_word.size() != 10) begin
            n_fail++; $display("FAIL prefill_count: got %0d expected 10", sh_word.size());
        end
        for (int i = 0; i < 10 && i < sh_word.size(); i++) begin
            n_cmp++;
            if (sh_word[i] !== rom_mem[i]) begin
                n_fail++; $display("FAIL prefill_word%0d: got %h expected %h", i, sh_word[i], rom_mem[i]);
            end
            n_cmp++;
            if (sh_cyc[i] != c0 + 2 + 3 * i) begin
                n_fail++; $display("FAIL prefill_cycle%0d: got %0d expected %0d", i, sh_cyc[i] - c0, 2 + 3 * i);
            end
        end
        n_cmp++;
        if (rdy_cyc != c0 + 30) begin
            n_fail++; $display("FAIL prefill_ready_cycle: got %0d expected 30", rdy_cyc - c0);
        end
        n_cmp++;
        if ({next_col, scroll_offset, scroll_active, level_end} !== {8'd10, 6'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL prefill_state: got col %0d off %0d act %b end %b expected 10 0 0 0",
                next_col, scroll_offset, scroll_active, level_end);
        end
        m_off = 0; m_next = 10; m_active = 1'b0; m_end = 1'b0;
    endtask

    task automatic test_scroll();
        int base;
        bit f;
        logic [9:0] x;
        base = sh_word.size();
        for (int k = 0; k < 20; k++) begin
            x = (k == 0) ? 10'd330 : ((k == 1) ? 10'd320 : 10'($urandom_range(320, 1023)));
            do_tick(x, 1'b1, 1'($urandom_range(0, 1)), f);
        end
        n_cmp++;
        if (scroll_offset !== 6'd0) begin
            n_fail++; $display("FAIL scroll_wrap_offset: got %0d expected 0", scroll_offset);
        end
        n_cmp++;
        if (sh_word.size() - base != 1) begin
            n_fail++; $display("FAIL scroll_shift_count: got %0d expected 1", sh_word.size() - base);
        end
    endtask

    task automatic test_no_scroll();
        bit f;
        do_tick(10'd330, 1'b1, 1'b0, f);
        do_tick(10'd319, 1'b1, 1'b0, f);
        do_tick(10'd300, 1'b1, 1'b0, f);
        for (int k = 0; k < 3; k++) do_tick(10'($urandom_range(0, 318)), 1'b1, 1'b0, f);
        for (int k = 0; k < 2; k++) do_tick(10'($urandom_range(320, 1023)), 1'b0, 1'b0, f);
    endtask

    task automatic test_level_end();
        int fetches, n;
        bit f;
        logic [9:0] x;
        logic r;
        fetches = 0;
        n = 0;
        while (!m_end && fetches < 3 && n < 400) begin
            r = ($urandom_range(0, 3) != 0);
            x = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(320, 1023)) : 10'($urandom_range(0, 319));
            do_tick(x, r, 1'($urandom_range(0, 1)), f);
            if (f) fetches++;
            n++;
        end
        for (int k = 0; k < 5; k++) do_tick(10'd330, 1'b1, 1'b0, f);
        n_cmp++;
`ifdef LEVEL_WRAP_EN
        if (level_end !== 1'b0) begin
            n_fail++; $display("FAIL level_end_final: got %b expected 0", level_end);
        end
`else
        if (level_end !== 1'b1) begin
            n_fail++; $display("FAIL level_end_final: got %b expected 1", level_end);
        end
`endif
    endtask

    task automatic test_rom_latency3();
        int c0, c1, nb;
        b_frame_tick = 1'b0; b_mx = 10'd330; b_mr = 1'b1;
        b_Reset = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 200 && b_ready !== 1'b1; i++) @(negedge Clk);
        n_cmp++;
        if (b_sh_word.size() != 10) begin
            n_fail++; $display("FAIL lat3_prefill_count: got %0d expected 10", b_sh_word.size());
        end
        for (int i = 0; i < 10 && i < b_sh_word.size(); i++) begin
            n_cmp++;
            if (b_sh_word[i] !== rom_mem[i] || b_sh_cyc[i] != c0 + 4 + 5 * i) begin
                n_fail++; $display("FAIL lat3_prefill%0d: got %h @%0d expected %h @%0d",
                    i, b_sh_word[i], b_sh_cyc[i] - c0, rom_mem[i], 4 + 5 * i);
            end
        end
        for (int k = 0; k < 19; k++) begin
            b_frame_tick = 1'b1;
            @(negedge Clk);
            b_frame_tick = 1'b0;
            repeat (3) @(negedge Clk);
        end
        n_cmp++;
        if (b_scroll_offset !== 6'd38) begin
            n_fail++; $display("FAIL lat3_offset: got %0d expected 38", b_scroll_offset);
        end
        nb = b_sh_word.size();
        b_frame_tick = 1'b1;
        @(negedge Clk);
        b_frame_tick = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (b_rom_addr !== 8'd10) begin
            n_fail++; $display("FAIL lat3_fetch_addr: got %0d expected 10", b_rom_addr);
        end
        repeat (2) @(negedge Clk);
        b_Reset = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if ({b_rom_addr, b_next_col, b_new_block_id, b_Shift, b_scroll_offset, b_scroll_active, b_ready, b_level_end} !== '0) begin
            n_fail++; $display("FAIL lat3_reset_outputs: got %h expected 0",
                {b_rom_addr, b_next_col, b_new_block_id, b_Shift, b_scroll_offset, b_scroll_active, b_ready, b_level_end});
        end
        @(negedge Clk);
        n_cmp++;
        if (b_sh_word.size() != nb) begin
            n_fail++; $display("FAIL lat3_reset_no_shift: got %0d expected %0d", b_sh_word.size(), nb);
        end
        b_Reset = 1'b0;
        c1 = cyc;
        for (int i = 0; i < 200 && b_ready !== 1'b1; i++) @(negedge Clk);
        n_cmp++;
        if (b_sh_word.size() != nb + 10) begin
            n_fail++; $display("FAIL lat3_refill_count: got %0d expected %0d", b_sh_word.size(), nb + 10);
        end
        for (int i = 0; i < 10 && nb + i < b_sh_word.size(); i++) begin
            n_cmp++;
            if (b_sh_word[nb + i] !== rom_mem[i] || b_sh_cyc[nb + i] != c1 + 4 + 5 * i) begin
                n_fail++; $display("FAIL lat3_refill%0d: got %h @%0d expected %h @%0d",
                    i, b_sh_word[nb + i], b_sh_cyc[nb + i] - c1, rom_mem[i], 4 + 5 * i);
            end
        end
        n_cmp++;
        if (b_next_col !== 8'd10) begin
            n_fail++; $display("FAIL lat3_next_col: got %0d expected 10", b_next_col);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 30'($urandom);
        m_off = 0; m_next = 0; m_active = 1'b0; m_end = 1'b0;
        test_reset();
        test_prefill();
        test_scroll();
        test_no_scroll();
        test_level_end();
        test_rom_latency3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/level_column_feeder.md
Name: level_column_feeder

Overview:
- Upstream stage of the block column store: produces `new_block_id` and the `Shift` strobe that load and scroll the 10-column on-screen block window.
- Reads 30-bit column words (10 rows x 3-bit block id, row 0 in bits [2:0]) from the synchronous level ROM.
- After reset, prefills the window with columns 0..9.
- During play, accumulates a per-frame pixel scroll offset while Mario pushes past the scroll line, and fetches/shifts one new column each time the offset crosses a 40-pixel block boundary.

Parameters:
- LEVEL_COLS, 200, total columns in level ROM; must be >= 10 and <= 256.
- ROM_LATENCY, 1, cycles from `rom_addr` change to valid `rom_data`; legal 1..3.
- SCROLL_X, 10'd320, Mario X pixel at or beyond which right motion scrolls the world.
- SCROLL_STEP, 2, pixels scrolled per `frame_tick`; legal 1..8.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- Mario_X_Pos  in  10  Mario centre X, screen pixels
- mario_moving_right  in  1  Mario has positive X velocity this frame
- rom_addr  out  8  level ROM column address
- rom_data  in  30  level ROM column word
- new_block_id  out  30  column word to shift into the window; stable from the Shift cycle until the next fetch captures
- Shift  out  1  one-cycle strobe: window shifts left, `new_block_id` enters column 9
- scroll_offset  out  6  sub-block pixel scroll, 0..39, for renderer
- scroll_active  out  1  world scrolled on the last accepted frame_tick; movement logic holds Mario X when high
- ready  out  1  prefill complete
- level_end  out  1  last column shifted in; scrolling disabled
- next_col  out  8  index of next column to fetch

Behaviour:
- Reset (wins over every other input, including a fetch in flight):
  - State PF_ISSUE.
  - rom_addr, next_col, new_block_id, Shift, scroll_offset, scroll_active, ready, level_end, fill_cnt, wait_cnt all = 0.
- States: PF_ISSUE, PF_WAIT, PF_SHIFT, RUN, F_ISSUE, F_WAIT, F_SHIFT.
- ISSUE (PF_/F_): `rom_addr <= next_col`; `wait_cnt <= ROM_LATENCY`; go to WAIT.
- WAIT:
  - Decrement `wait_cnt`.
  - When `wait_cnt` == 1, `new_block_id <= rom_data`; go to SHIFT.
- SHIFT:
  - `Shift` = 1 for exactly this cycle.
  - `next_col <= next_col + 1`.
  - PF_SHIFT: `fill_cnt++`. If `fill_cnt` was 9, `ready <= 1` and go to RUN; else go to PF_ISSUE.
  - F_SHIFT: return to RUN. If the new `next_col` == LEVEL_COLS, `level_end <= 1`.
- Latency: ISSUE to Shift = ROM_LATENCY+1 cycles; full prefill = 10*(ROM_LATENCY+2) cycles.
- RUN, on frame_tick:
  - Scroll condition: `mario_moving_right` && `Mario_X_Pos >= SCROLL_X` && !`level_end`.
  - Condition true:
    - `scroll_active <= 1`.
    - sum = `scroll_offset + SCROLL_STEP` (7-bit).
    - If sum >= 40: `scroll_offset <= sum - 40`, go to F_ISSUE.
    - Else `scroll_offset <= sum`.
  - Condition false: `scroll_active <= 0`; offset held.
- frame_tick while not in RUN (prefill or fetch): ignored. `scroll_active` and `scroll_offset` unchanged.
- Fetch is many orders shorter than a frame, so no tick is lost in normal operation.
- `frame_tick` and `Shift` in the same cycle: Shift completes; the tick is ignored.
- `level_end` is sticky until Reset. `scroll_offset` freezes at its value; `scroll_active` forced 0 on subsequent ticks.
- `next_col` never exceeds LEVEL_COLS; `rom_addr` never driven >= LEVEL_COLS.
- `ready` is 0 throughout prefill. Consumers ignore the Mario/Goomba polls until `ready`.

Optional Feature:
- Macro: LEVEL_WRAP_EN.
- Defined:
  - `next_col` wraps from LEVEL_COLS-1 to 0 at SHIFT (prefill included).
  - `level_end` is tied 0; scrolling continues indefinitely (attract/demo loop).
- Undefined: behaviour as above, stop at LEVEL_COLS.

Test Plan:
- Prefill, ROM_LATENCY=1, rom_data = {10{col[2:0]}} pattern:
  - Exactly 10 Shift pulses, 3 cycles apart.
  - `new_block_id` in each Shift cycle = word for col 0..9.
  - `ready` rises in the cycle after the 10th Shift; `next_col`=10.
- RUN, SCROLL_STEP=2, Mario_X=330, moving right, 20 ticks:
  - `scroll_offset` 2,4,..,38, then 0 on tick 20.
  - One Shift with the col-10 word; `scroll_active`=1 throughout.
- Mario_X=300 or `mario_moving_right`=0 on tick:
  - `scroll_offset` unchanged; `scroll_active`=0; no Shift.
- LEVEL_COLS=12: scroll until 2 fetches complete.
  - `level_end`=1 after Shift of col 11.
  - Further qualifying ticks: no Shift, `scroll_offset` frozen, `scroll_active`=0.
- ROM_LATENCY=3: data captured exactly 3 cycles after `rom_addr` change. Reset asserted during F_WAIT: Shift never pulses, all outputs 0 next cycle, prefill restarts at col 0.
- LEVEL_WRAP_EN, LEVEL_COLS=12: after col 11 Shift, `next_col`=0 and `rom_addr`=0 on next fetch; `level_end` stays 0.
